hilo_unit: RTL and testbench
============================

# hilo_unit

Sequencer and storage for the HI/LO register pair of the multicycle MIPS datapath. It accepts DIV, MULT, MTHI and MTLO requests from the control unit. For DIV and MULT it launches the divider or multiplier with a one-cycle start pulse, waits for that unit's stop flag and captures its 64-bit result into HI/LO. It raises divide-by-zero and timeout exceptions, and drives a busy flag the control unit uses to stall MFHI/MFLO and further HI/LO operations.

## Interface
- TIMEOUT, 40: maximum WAIT-state cycles before a launched operation is aborted.
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- w_OpValid  in  1  request strobe, sampled only in IDLE.
- w_HiLoOp  in  2  operation select:
  - 00 DIV
  - 01 MULT
  - 10 MTHI
  - 11 MTLO
- w_A, w_B  in  32  operands, latched at acceptance. MTHI/MTLO use w_A.
- w_DivStart  out  1  one-cycle launch pulse to divider.
- w_DivStop  in  1  divider completion flag.
- w_DIVHI, w_DIVLO  in  32  divider remainder / quotient.
- w_MultStart  out  1  one-cycle launch pulse to multiplier.
- w_MultStop  in  1  multiplier completion flag.
- w_MULTHI, w_MULTLO  in  32  product upper / lower word.
- w_HI, w_LO  out  32  architectural HI/LO registers.
- w_HiLoBusy  out  1  high whenever state is not IDLE.
- w_HiLoDone  out  1  one-cycle pulse when a request finishes, including aborted ones.
- w_DivZeroExc  out  1  one-cycle pulse: DIV with w_B == 0.
- w_HiLoTimeout  out  1  one-cycle pulse: no stop within TIMEOUT cycles.

## Operation
- States: IDLE, LAUNCH, WAIT.
- IDLE with w_OpValid high, at edge E0:
  - MTHI: HI <= w_A, Done pulses; stay IDLE.
  - MTLO: LO <= w_A, Done pulses; stay IDLE.
  - DIV with w_B == 0: DivZeroExc and Done pulse; HI/LO unchanged; the divider is never started; stay IDLE.
  - DIV with w_B != 0, or any MULT: latch the op kind, go to LAUNCH.
- LAUNCH (exactly one cycle):
  - w_DivStart high for DIV, w_MultStart high for MULT; the other start stays low.
  - Wait counter cleared.
  - Go to WAIT.
  - Stop inputs are ignored in LAUNCH, because stop may still be stale from the previous operation.
- WAIT: the selected unit's stop flag is sampled each edge; the non-selected unit's stop is ignored.
  - On an edge where stop is high: {HI, LO} <= {w_DIVHI, w_DIVLO} or {w_MULTHI, w_MULTLO}; Done pulses; go to IDLE.
  - Otherwise the counter increments.
  - If the TIMEOUT-th WAIT edge passes with no stop: HiLoTimeout and Done pulse; HI/LO unchanged; go to IDLE.
  - If stop and timeout fall on the same edge, stop wins: result is captured and no timeout is flagged.
- Requests presented while Busy are ignored and not queued. The control unit must hold w_OpValid until it sees Busy or Done.
- An MTHI/MTLO accepted in IDLE completes before any later DIV/MULT; ordering follows acceptance order.
- Results are stored bit-for-bit as delivered by the units. No sign fix-up is done here.
- Reset (any state, including mid-WAIT):
  - State goes to IDLE; HI and LO go to 0.
  - Both starts, Busy, Done, DivZeroExc and HiLoTimeout go to 0; counter goes to 0.
  - A unit left running is abandoned, and its later stop is ignored because state is IDLE.

## Timing
- All outputs are registered.
- MTHI/MTLO: new value on w_HI/w_LO and Done high in the cycle after E0. Busy never asserts.
- DIV/MULT: Busy high from the cycle after E0 through the capture edge.
  - Start is high in the cycle after E0; the unit samples it at edge E1.
  - Earliest capture is at E2 (stop seen in the first WAIT cycle). New HI/LO and Done appear together in the cycle after the capture edge, in the same cycle Busy drops.
- Divide-by-zero: DivZeroExc and Done in the cycle after E0; zero-cycle busy.
- Timeout: exception pulse in the cycle after the TIMEOUT-th WAIT edge, so Busy lasts TIMEOUT+1 cycles.
- Back-to-back: a new request can be accepted on the edge after Busy falls.

## Test plan
- Reset, then MTHI w_A=0x12345678, then MTLO w_A=0x9ABCDEF0 -> w_HI=0x12345678, w_LO=0x9ABCDEF0; each Done pulses one cycle after its request; Busy stays 0.
- DIV w_A=100, w_B=7; divider model raises stop 33 cycles after start with DIVHI=2, DIVLO=14 -> w_DivStart high for exactly one cycle; Busy high 34 cycles; HI=2, LO=14; Done one cycle.
- DIV w_B=0 with HI=0xAAAA0000, LO=0x0000BBBB -> DivZeroExc and Done pulse the next cycle; w_DivStart never rises; HI/LO unchanged.
- MULT with stop held low, TIMEOUT=40 -> HiLoTimeout pulse after 41 Busy cycles; HI/LO unchanged. A second MULT whose stop arrives exactly on the 40th WAIT edge -> result captured, no timeout.
- MULT accepted, then Reset asserted during WAIT, then late w_MultStop -> HI=LO=0, Busy=0, no Done, late stop ignored.
- w_OpValid held high with MTHI while Busy from a DIV; stale w_DivStop high during LAUNCH -> MTHI ignored until IDLE; stale stop not captured; DIV result written only on the genuine stop.

Source files
------------

// File: rtl/hilo_unit_if.sv
// Request, status and divider/multiplier handshake bundle for the HI/LO sequencer.
// The slave modport is the sequencer's view; master is the control/arith side.
interface hilo_unit_if;
  logic        w_OpValid;
  logic [1:0]  w_HiLoOp;
  logic [31:0] w_A;
  logic [31:0] w_B;
  logic        w_DivStart;
  logic        w_DivStop;
  logic [31:0] w_DIVHI;
  logic [31:0] w_DIVLO;
  logic        w_MultStart;
  logic        w_MultStop;
  logic [31:0] w_MULTHI;
  logic [31:0] w_MULTLO;
  logic [31:0] w_HI;
  logic [31:0] w_LO;
  logic        w_HiLoBusy;
  logic        w_HiLoDone;
  logic        w_DivZeroExc;
  logic        w_HiLoTimeout;

  modport slave (
    input  w_OpValid, w_HiLoOp, w_A, w_B,
    input  w_DivStop, w_DIVHI, w_DIVLO,
    input  w_MultStop, w_MULTHI, w_MULTLO,
    output w_DivStart, w_MultStart, w_HI, w_LO,
    output w_HiLoBusy, w_HiLoDone, w_DivZeroExc, w_HiLoTimeout
  );

  modport master (
    output w_OpValid, w_HiLoOp, w_A, w_B,
    output w_DivStop, w_DIVHI, w_DIVLO,
    output w_MultStop, w_MULTHI, w_MULTLO,
    input  w_DivStart, w_MultStart, w_HI, w_LO,
    input  w_HiLoBusy, w_HiLoDone, w_DivZeroExc, w_HiLoTimeout
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with DIV/MULT launch, completion capture, divide-by-zero
// and timeout handling. Every output comes straight from a flop.
module hilo_unit #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clock,
  input  logic        Reset,
  hilo_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t             state_q, state_d;
  logic               op_div_q, op_div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               div_start_q, div_start_d;
  logic               mult_start_q, mult_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               to_q, to_d;
  logic               stop_sel;

  // Only the launched unit's stop is meaningful; the other may be stale or busy.
  assign stop_sel = op_div_q ? bus.w_DivStop : bus.w_MultStop;

  always_comb begin
    state_d      = state_q;
    op_div_d     = op_div_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_start_d  = 1'b0;
    mult_start_d = 1'b0;
    done_d       = 1'b0;
    dz_d         = 1'b0;
    to_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.w_OpValid) begin
          case (bus.w_HiLoOp)
            OP_MTHI: begin
              hi_d   = bus.w_A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.w_A;
              done_d = 1'b1;
            end
            OP_DIV: begin
              if (bus.w_B == 32'd0) begin
                dz_d   = 1'b1;
                done_d = 1'b1;
              end else begin
                op_div_d    = 1'b1;
                div_start_d = 1'b1;
                state_d     = LAUNCH;
              end
            end
            OP_MULT: begin
              op_div_d     = 1'b0;
              mult_start_d = 1'b1;
              state_d      = LAUNCH;
            end
            default: ;
          endcase
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A stop on the final allowed edge still counts as completion.
        if (stop_sel) begin
          hi_d    = op_div_q ? bus.w_DIVHI : bus.w_MULTHI;
          lo_d    = op_div_q ? bus.w_DIVLO : bus.w_MULTLO;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      op_div_q     <= 1'b0;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_start_q  <= 1'b0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dz_q         <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_div_q     <= op_div_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_start_q  <= div_start_d;
      mult_start_q <= mult_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dz_q         <= dz_d;
      to_q         <= to_d;
    end
  end

  assign bus.w_HI          = hi_q;
  assign bus.w_LO          = lo_q;
  assign bus.w_DivStart    = div_start_q;
  assign bus.w_MultStart   = mult_start_q;
  assign bus.w_HiLoBusy    = busy_q;
  assign bus.w_HiLoDone    = done_q;
  assign bus.w_DivZeroExc  = dz_q;
  assign bus.w_HiLoTimeout = to_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: register moves, DIV/MULT completion, divide-by-zero,
// timeout boundary, mid-operation reset, stale stop and held request.
module tb_hilo_unit;
  localparam int TIMEOUT = 40;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  hilo_unit_if bus();

  hilo_unit #(.TIMEOUT(TIMEOUT)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int busy_n, dstart_n, mstart_n, done_n, dz_n, to_n, done_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic move(input logic [1:0] op, input logic [31:0] val);
    bus.w_OpValid = 1'b1;
    bus.w_HiLoOp  = op;
    bus.w_A       = val;
    step();
    bus.w_OpValid = 1'b0;
    step();
  endtask

  // Issue one request and observe cycles c1.. after acceptance until Done.
  // stop_at: cycle in which the selected unit's stop is driven high (-1 = never).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stop_at, input logic [31:0] rhi, input logic [31:0] rlo,
                        input bit stale, input bit noise, input bit hold,
                        input logic [31:0] hold_a);
    logic s;
    logic [31:0] dh, dl;
    busy_n = 0; dstart_n = 0; mstart_n = 0; done_n = 0; dz_n = 0; to_n = 0; done_cyc = 0;
    bus.w_OpValid = 1'b1;
    bus.w_HiLoOp  = op;
    bus.w_A       = a;
    bus.w_B       = b;
    step();
    if (hold) begin
      bus.w_HiLoOp = 2'b10;
      bus.w_A      = hold_a;
    end else begin
      bus.w_OpValid = 1'b0;
    end
    for (int cyc = 1; cyc <= 100; cyc++) begin
      busy_n   += int'(bus.w_HiLoBusy);
      dstart_n += int'(bus.w_DivStart);
      mstart_n += int'(bus.w_MultStart);
      dz_n     += int'(bus.w_DivZeroExc);
      to_n     += int'(bus.w_HiLoTimeout);
      if (bus.w_HiLoDone) begin
        done_n++;
        done_cyc = cyc;
        break;
      end
      s  = (cyc == stop_at) || (stale && cyc == 1);
      dh = (cyc == stop_at) ? rhi : 32'hDEADBEEF;
      dl = (cyc == stop_at) ? rlo : 32'hDEADBEEF;
      if (op == 2'b00) begin
        bus.w_DivStop  = s;     bus.w_DIVHI  = dh;           bus.w_DIVLO  = dl;
        bus.w_MultStop = noise; bus.w_MULTHI = 32'h55555555; bus.w_MULTLO = 32'h55555555;
      end else begin
        bus.w_MultStop = s;     bus.w_MULTHI = dh;           bus.w_MULTLO = dl;
        bus.w_DivStop  = noise; bus.w_DIVHI  = 32'h55555555; bus.w_DIVLO  = 32'h55555555;
      end
      step();
    end
    bus.w_DivStop  = 1'b0;
    bus.w_MultStop = 1'b0;
  endtask

  initial begin
    bus.w_OpValid = 1'b0; bus.w_HiLoOp = 2'b00; bus.w_A = '0; bus.w_B = '0;
    bus.w_DivStop = 1'b0; bus.w_DIVHI = '0; bus.w_DIVLO = '0;
    bus.w_MultStop = 1'b0; bus.w_MULTHI = '0; bus.w_MULTLO = '0;
    Reset = 1'b1;
    step();
    step();
    check("rst_hi", bus.w_HI, 0);
    check("rst_lo", bus.w_LO, 0);
    check("rst_busy", bus.w_HiLoBusy, 0);
    check("rst_done", bus.w_HiLoDone, 0);
    check("rst_starts", {bus.w_DivStart, bus.w_MultStart}, 0);
    check("rst_exc", {bus.w_DivZeroExc, bus.w_HiLoTimeout}, 0);
    Reset = 1'b0;
    step();

    // MTHI / MTLO
    bus.w_OpValid = 1'b1; bus.w_HiLoOp = 2'b10; bus.w_A = 32'h12345678;
    step();
    check("mthi_hi", bus.w_HI, 32'h12345678);
    check("mthi_done", bus.w_HiLoDone, 1);
    check("mthi_busy", bus.w_HiLoBusy, 0);
    bus.w_HiLoOp = 2'b11; bus.w_A = 32'h9ABCDEF0;
    step();
    check("mtlo_lo", bus.w_LO, 32'h9ABCDEF0);
    check("mtlo_hi", bus.w_HI, 32'h12345678);
    check("mtlo_done", bus.w_HiLoDone, 1);
    check("mtlo_busy", bus.w_HiLoBusy, 0);
    bus.w_OpValid = 1'b0;
    step();
    check("mt_done_clr", bus.w_HiLoDone, 0);

    // DIV 100/7, stop 33 cycles after start
    run_op(2'b00, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 32'h0);
    check("div_dstart", dstart_n, 1);
    check("div_mstart", mstart_n, 0);
    check("div_busy", busy_n, 34);
    check("div_done_cyc", done_cyc, 35);
    check("div_hi", bus.w_HI, 32'd2);
    check("div_lo", bus.w_LO, 32'd14);
    step();
    check("div_done_len", bus.w_HiLoDone, 0);

    // Divide by zero
    move(2'b10, 32'hAAAA0000);
    move(2'b11, 32'h0000BBBB);
    run_op(2'b00, 32'd5, 32'd0, -1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("dz_done_cyc", done_cyc, 1);
    check("dz_exc", dz_n, 1);
    check("dz_dstart", dstart_n, 0);
    check("dz_busy", busy_n, 0);
    check("dz_hilo", {bus.w_HI, bus.w_LO}, 64'hAAAA0000_0000BBBB);
    step();
    check("dz_exc_clr", {bus.w_DivZeroExc, bus.w_HiLoDone, bus.w_DivStart}, 0);

    // MULT timeout, divider stop toggling high meanwhile
    run_op(2'b01, 32'd3, 32'd4, -1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("to_busy", busy_n, 41);
    check("to_flag", to_n, 1);
    check("to_done_cyc", done_cyc, 42);
    check("to_mstart", mstart_n, 1);
    check("to_dstart", dstart_n, 0);
    check("to_hilo", {bus.w_HI, bus.w_LO}, 64'hAAAA0000_0000BBBB);
    step();
    check("to_clr", {bus.w_HiLoTimeout, bus.w_HiLoDone}, 0);

    // MULT stop on the 40th WAIT edge: capture wins
    run_op(2'b01, 32'd3, 32'd4, 41, 32'h11112222, 32'h33334444, 1'b0, 1'b0, 1'b0, 32'h0);
    check("edge_busy", busy_n, 41);
    check("edge_to", to_n, 0);
    check("edge_done_cyc", done_cyc, 42);
    check("edge_hilo", {bus.w_HI, bus.w_LO}, 64'h11112222_33334444);
    step();

    // Reset during WAIT, then a late stop
    bus.w_OpValid = 1'b1; bus.w_HiLoOp = 2'b01;
    step();
    bus.w_OpValid = 1'b0;
    step();
    step();
    step();
    check("rw_busy_pre", bus.w_HiLoBusy, 1);
    Reset = 1'b1;
    step();
    check("rw_hilo", {bus.w_HI, bus.w_LO}, 0);
    check("rw_busy", bus.w_HiLoBusy, 0);
    check("rw_done", bus.w_HiLoDone, 0);
    Reset = 1'b0;
    bus.w_MultStop = 1'b1; bus.w_MULTHI = 32'h0000FFFF; bus.w_MULTLO = 32'hFFFF0000;
    step();
    step();
    check("late_hilo", {bus.w_HI, bus.w_LO}, 0);
    check("late_done", {bus.w_HiLoDone, bus.w_HiLoBusy}, 0);
    bus.w_MultStop = 1'b0;
    step();

    // DIV with stale stop in LAUNCH and MTHI held during busy
    run_op(2'b00, 32'd50, 32'd6, 2, 32'd2, 32'd8, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);
    check("st_busy", busy_n, 2);
    check("st_done_cyc", done_cyc, 3);
    check("st_dstart", dstart_n, 1);
    check("st_hilo", {bus.w_HI, bus.w_LO}, 64'h00000002_00000008);
    step();
    check("hold_hi", bus.w_HI, 32'hCAFEF00D);
    check("hold_lo", bus.w_LO, 32'd8);
    check("hold_done", bus.w_HiLoDone, 1);
    bus.w_OpValid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
